// File: rtl/edge_detect_pkg.sv
// Shared types and limits for the edge detector array.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  localparam int unsigned MAX_SYNC_STAGES     = 4;
  localparam int unsigned MAX_DEBOUNCE_CYCLES = 65535;
  localparam int unsigned DEB_CNT_W           = 16;

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: synchronizer, optional debounce filter and mode-selected edge pulse.
module edge_detect_channel
  import edge_detect_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic       pulse_c
);

  localparam int unsigned SYNC_N = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;
  localparam int unsigned DEB_N  = (DEBOUNCE_CYCLES > MAX_DEBOUNCE_CYCLES) ?
                                   MAX_DEBOUNCE_CYCLES : DEBOUNCE_CYCLES;

  logic       s;
  logic       a;
  logic       a_prev;
  edge_mode_t mode_e;

  generate
    if (SYNC_N == 0) begin : g_nosync
      assign s = d;
    end else begin : g_sync
      logic [SYNC_N-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= SYNC_N'({sync_q, d});
      end
      assign s = sync_q[SYNC_N-1];
    end
  endgenerate

  generate
    if (DEB_N == 0) begin : g_nodeb
      always_ff @(posedge clk) begin
        if (reset) a <= 1'b0;
        else       a <= s;
      end
    end else begin : g_deb
      // Filter runs on a registered copy of s so acceptance lands exactly N cycles later.
      localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_N - 1);
      logic                 s_q;
      logic [DEB_CNT_W-1:0] cnt;
      always_ff @(posedge clk) begin
        if (reset) begin
          s_q <= 1'b0;
          a   <= 1'b0;
          cnt <= '0;
        end else begin
          s_q <= s;
          if (s_q == a) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            a   <= s_q;
            cnt <= '0;
          end else begin
            cnt <= cnt + DEB_CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  assign mode_e = edge_mode_t'(mode);

  // Edge qualification against the previous accepted level.
  always_comb begin
    pulse_c = 1'b0;
    case (mode_e)
      EDGE_RISE: pulse_c = a & ~a_prev;
      EDGE_FALL: pulse_c = ~a & a_prev;
      EDGE_BOTH: pulse_c = a ^ a_prev;
      default:   pulse_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      a_prev <= a;
      pulse  <= pulse_c;
    end
  end

endmodule

// File: rtl/edge_detect_array.sv
// Array of independent edge detectors with sticky pending flags and lowest-index encoder.
module edge_detect_array
  import edge_detect_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  localparam int unsigned IDX_W          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clear,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   pending,
  output logic               any_pending,
  output logic [IDX_W-1:0]   first_idx
);

  logic [WIDTH-1:0] pulse_set;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      edge_detect_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .d       (d[i]),
        .mode    (mode[2*i +: 2]),
        .pulse   (pulse[i]),
        .pulse_c (pulse_set[i])
      );
    end
  endgenerate

  // A new edge outranks a clear strobe landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clear) | pulse_set;
  end

  assign any_pending = |pending;

  always_comb begin
    first_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_edge_detect_array.sv
// Randomized and directed checks of edge_detect_array against a sample-stream reference model.
module tb_edge_detect_array;

  localparam int W     = 8;
  localparam int SYNC  = 2;
  localparam int DEB_B = 4;
  // Pulse follows the sample that changes the accepted level by SYNC+1 cycles without
  // debounce; with debounce the level is accepted on the Nth stable sample, so SYNC+1+N
  // from the first stable sample is SYNC+2 from the accepting sample.
  localparam int TAP_A = SYNC + 1;
  localparam int TAP_B = SYNC + 2;

  logic           clk;
  logic           reset;
  logic [W-1:0]   d_a, d_b, clear_a, clear_b;
  logic [2*W-1:0] mode_a, mode_b;
  logic [W-1:0]   pulse_a, pulse_b, pend_a, pend_b;
  logic           any_a, any_b;
  logic [2:0]     fidx_a, fidx_b;

  int checks   = 0;
  int failures = 0;

  edge_detect_array #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .d(d_a), .mode(mode_a), .clear(clear_a),
    .pulse(pulse_a), .pending(pend_a), .any_pending(any_a), .first_idx(fidx_a)
  );

  edge_detect_array #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB_B)) dut_b (
    .clk(clk), .reset(reset), .d(d_b), .mode(mode_b), .clear(clear_b),
    .pulse(pulse_b), .pending(pend_b), .any_pending(any_b), .first_idx(fidx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] fh_a [0:7];
  logic [W-1:0] fh_b [0:7];
  logic [W-1:0] filt_b;
  int           run_b [W];
  logic [W-1:0] exp_pulse_a, exp_pulse_b, exp_pend_a, exp_pend_b;

  function automatic logic [W-1:0] edges_of(input logic [W-1:0] now, input logic [W-1:0] prev,
                                            input logic [2*W-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      r[i] = (m[2*i] & now[i] & ~prev[i]) | (m[2*i+1] & ~now[i] & prev[i]);
    return r;
  endfunction

  function automatic logic [2:0] lowest(input logic [W-1:0] p);
    for (int i = 0; i < W; i++)
      if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 8; j++) begin
        fh_a[j] = '0;
        fh_b[j] = '0;
      end
      for (int i = 0; i < W; i++) run_b[i] = 0;
      filt_b      = '0;
      exp_pulse_a = '0;
      exp_pulse_b = '0;
      exp_pend_a  = '0;
      exp_pend_b  = '0;
    end else begin
      for (int j = 7; j > 0; j--) begin
        fh_a[j] = fh_a[j-1];
        fh_b[j] = fh_b[j-1];
      end
      fh_a[0] = d_a;
      // Accept a new level after DEB_B consecutive samples that differ from the current one.
      for (int i = 0; i < W; i++) begin
        if (d_b[i] == filt_b[i]) begin
          run_b[i] = 0;
        end else begin
          run_b[i]++;
          if (run_b[i] == DEB_B) begin
            filt_b[i] = d_b[i];
            run_b[i]  = 0;
          end
        end
      end
      fh_b[0]     = filt_b;
      exp_pulse_a = edges_of(fh_a[TAP_A], fh_a[TAP_A+1], mode_a);
      exp_pulse_b = edges_of(fh_b[TAP_B], fh_b[TAP_B+1], mode_b);
      exp_pend_a  = (exp_pend_a & ~clear_a) | exp_pulse_a;
      exp_pend_b  = (exp_pend_b & ~clear_b) | exp_pulse_b;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    step(3);
    checks++; if (pulse_a !== 8'h00) begin failures++; $display("FAIL reset_pulse_a got=%h exp=00", pulse_a); end
    checks++; if (pend_a !== 8'h00) begin failures++; $display("FAIL reset_pend_a got=%h exp=00", pend_a); end
    checks++; if (any_a !== 1'b0) begin failures++; $display("FAIL reset_any_a got=%b exp=0", any_a); end
    checks++; if (fidx_a !== 3'd0) begin failures++; $display("FAIL reset_fidx_a got=%0d exp=0", fidx_a); end
    checks++; if (pulse_b !== 8'h00 || pend_b !== 8'h00) begin
      failures++; $display("FAIL reset_b got=%h/%h exp=00/00", pulse_b, pend_b);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_rise;
    mode_a = {W{2'b01}};
    d_a    = '0;
    step(6);
    d_a[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step(1);
      checks++;
      if (pulse_a[0] !== (c == SYNC + 1)) begin
        failures++; $display("FAIL rise_latency edge=%0d got=%b exp=%b", c, pulse_a[0], c == SYNC + 1);
      end
    end
    checks++; if (pend_a !== 8'h01) begin failures++; $display("FAIL rise_pend got=%h exp=01", pend_a); end
    checks++; if (fidx_a !== 3'd0 || any_a !== 1'b1) begin
      failures++; $display("FAIL rise_idx got=%0d/%b exp=0/1", fidx_a, any_a);
    end
  endtask

  task automatic test_both;
    int n;
    logic [W-1:0] pend_before;
    mode_a[7:6] = 2'b11;
    d_a[3] = 1'b1;
    step(1);
    d_a[3] = 1'b0;
    n = 0;
    for (int c = 0; c < 9; c++) begin
      step(1);
      if (pulse_a[3]) n++;
      checks++;
      if (pulse_a !== exp_pulse_a) begin
        failures++; $display("FAIL both_model c=%0d got=%h exp=%h", c, pulse_a, exp_pulse_a);
      end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL both_count got=%0d exp=2", n); end
    checks++; if (pend_a[3] !== 1'b1) begin failures++; $display("FAIL both_pend got=%b exp=1", pend_a[3]); end
    mode_a[7:6] = 2'b00;
    pend_before = pend_a;
    d_a[3] = 1'b1;
    step(1);
    d_a[3] = 1'b0;
    n = 0;
    for (int c = 0; c < 9; c++) begin
      step(1);
      if (pulse_a[3]) n++;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL none_count got=%0d exp=0", n); end
    checks++; if (pend_a !== pend_before) begin
      failures++; $display("FAIL none_pend got=%h exp=%h", pend_a, pend_before);
    end
  endtask

  task automatic test_debounce;
    int n;
    mode_b = {W{2'b01}};
    d_b    = '0;
    step(10);
    d_b[1] = 1'b1;
    step(3);
    d_b[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      step(1);
      if (pulse_b[1]) n++;
    end
    checks++; if (n != 0 || pend_b[1] !== 1'b0) begin
      failures++; $display("FAIL deb_glitch pulses=%0d pend=%b exp=0/0", n, pend_b[1]);
    end
    d_b[1] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      step(1);
      checks++;
      if (pulse_b[1] !== (c == SYNC + 1 + DEB_B)) begin
        failures++; $display("FAIL deb_latency edge=%0d got=%b exp=%b", c, pulse_b[1], c == SYNC + 1 + DEB_B);
      end
    end
    checks++; if (pend_b !== 8'h02) begin failures++; $display("FAIL deb_pend got=%h exp=02", pend_b); end
  endtask

  task automatic test_pending;
    mode_a  = {W{2'b01}};
    clear_a = 8'hFF;
    step(1);
    clear_a = 8'h00;
    checks++; if (pend_a !== 8'h00) begin failures++; $display("FAIL pend_clear_all got=%h exp=00", pend_a); end
    d_a[2] = 1'b1;
    d_a[5] = 1'b1;
    step(6);
    checks++; if (pend_a !== 8'h24 || fidx_a !== 3'd2) begin
      failures++; $display("FAIL pend_set got=%h/%0d exp=24/2", pend_a, fidx_a);
    end
    clear_a = 8'h04;
    step(1);
    clear_a = 8'h00;
    checks++; if (pend_a !== 8'h20 || fidx_a !== 3'd5 || any_a !== 1'b1) begin
      failures++; $display("FAIL pend_clear2 got=%h/%0d/%b exp=20/5/1", pend_a, fidx_a, any_a);
    end
    d_a[5] = 1'b0;
    step(6);
    clear_a = 8'h20;
    step(1);
    clear_a = 8'h00;
    checks++; if (pend_a !== 8'h00) begin failures++; $display("FAIL pend_clear5 got=%h exp=00", pend_a); end
    d_a[5] = 1'b1;
    step(SYNC + 1);
    clear_a = 8'h20;
    step(1);
    clear_a = 8'h00;
    checks++; if (pulse_a[5] !== 1'b1 || pend_a[5] !== 1'b1) begin
      failures++; $display("FAIL set_wins pulse=%b pend=%b exp=1/1", pulse_a[5], pend_a[5]);
    end
  endtask

  task automatic test_reset_release;
    int nfull;
    int nbits;
    reset   = 1'b1;
    d_a     = 8'hFF;
    mode_a  = {W{2'b01}};
    clear_a = 8'h00;
    step(3);
    checks++; if (pend_a !== 8'h00 || pulse_a !== 8'h00) begin
      failures++; $display("FAIL rr_in_reset got=%h/%h exp=00/00", pend_a, pulse_a);
    end
    reset = 1'b0;
    nfull = 0;
    nbits = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (pulse_a == 8'hFF) nfull++;
      nbits += $countones(pulse_a);
    end
    checks++; if (nfull != 1 || nbits != 8) begin
      failures++; $display("FAIL rr_pulse full=%0d bits=%0d exp=1/8", nfull, nbits);
    end
    d_b = '0;
    step(10);
    d_b = 8'hFF;
    step(4);
    reset = 1'b1;
    d_b   = '0;
    step(2);
    reset = 1'b0;
    nbits = 0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      nbits += $countones(pulse_b);
    end
    checks++; if (nbits != 0 || pend_b !== 8'h00) begin
      failures++; $display("FAIL rr_mid_deb bits=%0d pend=%h exp=0/00", nbits, pend_b);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      step(1);
      checks++; if (pulse_a !== exp_pulse_a) begin failures++; $display("FAIL rnd_pulse_a c=%0d got=%h exp=%h", c, pulse_a, exp_pulse_a); end
      checks++; if (pend_a !== exp_pend_a) begin failures++; $display("FAIL rnd_pend_a c=%0d got=%h exp=%h", c, pend_a, exp_pend_a); end
      checks++; if (any_a !== (exp_pend_a != 0) || fidx_a !== lowest(exp_pend_a)) begin
        failures++; $display("FAIL rnd_idx_a c=%0d got=%b/%0d exp=%b/%0d", c, any_a, fidx_a, exp_pend_a != 0, lowest(exp_pend_a));
      end
      checks++; if (pulse_b !== exp_pulse_b) begin failures++; $display("FAIL rnd_pulse_b c=%0d got=%h exp=%h", c, pulse_b, exp_pulse_b); end
      checks++; if (pend_b !== exp_pend_b) begin failures++; $display("FAIL rnd_pend_b c=%0d got=%h exp=%h", c, pend_b, exp_pend_b); end
      checks++; if (any_b !== (exp_pend_b != 0) || fidx_b !== lowest(exp_pend_b)) begin
        failures++; $display("FAIL rnd_idx_b c=%0d got=%b/%0d exp=%b/%0d", c, any_b, fidx_b, exp_pend_b != 0, lowest(exp_pend_b));
      end
      d_a     = d_a ^ (8'($urandom) & 8'($urandom));
      d_b     = d_b ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      clear_a = 8'($urandom) & 8'($urandom) & 8'($urandom);
      clear_b = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) mode_a = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mode_b = 16'($urandom);
      reset = ($urandom_range(0, 149) == 0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    d_a     = '0;
    d_b     = '0;
    clear_a = '0;
    clear_b = '0;
    mode_a  = '0;
    mode_b  = '0;
    test_reset();
    test_rise();
    test_both();
    test_debounce();
    test_pending();
    test_reset_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
